wb_io_msi_ctrl: RTL and testbench
=================================

// Module: wb_io_msi_ctrl
// PURPOSE
//  I/O-side device on one channel of the 256-bit I/O bridge: consumes bridge m_req, drives that channel's chresp.
//  Latches rising edges on NIRQ interrupt inputs and emits each as a one-cycle MSI response (ack=1, err=IRQ)
//  that the bridge queues in its per-channel MSI FIFO. Also serves a small register space (pending/enable/control).
// PARAMETERS
//  NIRQ      8               number of interrupt inputs, 1..32
//  BASE_ADR  32'hFEE20000    register block base address
//  ADR_MASK  32'hFFFFFFE0    address compare mask (32-byte block, four 64-bit registers)
//  MSI_PRI   4'd8            value driven on resp.pri for MSI responses
// PORTS
//  clk_i   in   1          clock
//  rst_i   in   1          reset, asynchronous, active-high
//  req     in   wb_cmd_request256_t   bridge master request (m_req)
//  resp    out  wb_cmd_response256_t  channel response (chresp[n])
//  irq_i   in   NIRQ       level interrupt sources, synchronous to clk_i
// BEHAVIOUR
//  Reset (async): resp all-zero; PEND=0, ENABLE=0, CTRL=0; irq edge history=0; state=IDLE.
//  Hit: req.cyc & req.stb & ((req.adr & ADR_MASK)==(BASE_ADR & ADR_MASK)). Non-hit: no response, no state change.
//  Registers (index adr[4:3]): 0 PEND (R, write-1-to-clear), 1 ENABLE (RW), 2 CTRL (RW: [7:0] vector base,
//   [8] global enable, [31:16] MSI tid), 3 STATUS (R: [5:0] index of last MSI, [8] any pending&enabled).
//  Write data from 64-bit lane adr[4:3]; write only if any sel bit of that lane set. Read data replicated on all 4 lanes.
//  Edge detect: irq_q <= irq_i; set PEND[i] on irq_i[i] & ~irq_q[i]. Set beats W1C in same cycle. Already-pending edge: no-op.
//  FSM states:
//   IDLE: hit -> BUS_ACK (resp.ack=1, err=OKAY, tid=req.tid, dat=read data; write applied same edge). Latency 1 clock.
//         else if CTRL[8] & |(PEND&ENABLE) -> MSI: lowest set index k; PEND[k] cleared; resp.ack=1, err=IRQ,
//         dat[7:0]=vector base+k (8-bit wrap), other dat bits 0, tid=CTRL[31:16], pri=MSI_PRI.
//   BUS_ACK: hold resp unchanged while req.stb; on !req.stb resp<=0 -> IDLE. One access per stb (cti/blen ignored).
//   MSI: exactly one cycle of ack; resp<=0 -> GAP. (bridge FIFO writes once per ack cycle.)
//   GAP: one idle cycle guaranteeing ack low between MSIs -> IDLE.
//  Bus access has priority over MSI in IDLE; a hit arriving in MSI/GAP is acked on the first IDLE cycle after.
//  Pending but disabled bits stay pending; enabling later produces the MSI. Clearing CTRL[8] blocks new MSIs only.
//  Max MSI rate one per 3 clocks. rst_i mid-transaction clears resp immediately.
// STRUCTURE
//  wishbone_pkg: reuse wb_cmd_request256_t, wb_cmd_response256_t, OKAY/IRQ err codes; add MSI register offset constants.
//  One sub-module natural: wb_msi_prienc (NIRQ-bit lowest-set priority encoder -> index + valid).
// TESTING
//  1. Reset, irq_i[3] 0->1, CTRL=0x0001_0140, ENABLE=0x08 -> one cycle resp.ack=1, err=IRQ, dat[7:0]=0x43, tid=0x0001.
//  2. Read 0xFEE20008 with ENABLE=0xA5 -> ack next cycle, dat 64'hA5 on all 4 lanes, held until stb drops, then 0.
//  3. irq_i[0],[5] rise same cycle -> MSIs for 0 then 5, three cycles apart, ack low in between; PEND=0 after.
//  4. W1C PEND bit 2 coincident with irq_i[2] rising edge -> PEND[2] remains 1.
//  5. Hit read issued during MSI cycle -> MSI completes, read ack appears in first IDLE cycle, data correct.
//  6. irq_i[1] rises with ENABLE[1]=0 -> no MSI, STATUS[8]=0; set ENABLE[1] -> MSI vector base+1.

Source files
------------

// File: rtl/wb_io_msi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// wb_io_msi_ctrl_pkg
// Bridge request/response types, error codes and MSI register map constants.
// Revision: 1.0
// ============================================================================
package wb_io_msi_ctrl_pkg;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  adr;
        logic [31:0]  sel;
        logic [255:0] dat;
        logic [15:0]  tid;
        logic [2:0]   cti;
        logic [7:0]   blen;
    } wb_cmd_request256_t;

    typedef struct packed {
        logic         ack;
        logic [1:0]   err;
        logic [3:0]   pri;
        logic [15:0]  tid;
        logic [255:0] dat;
    } wb_cmd_response256_t;

    localparam logic [1:0] WB_ERR_OKAY = 2'd0;
    localparam logic [1:0] WB_ERR_ERR  = 2'd1;
    localparam logic [1:0] WB_ERR_IRQ  = 2'd2;

    localparam logic [1:0] MSI_REG_PEND   = 2'd0;
    localparam logic [1:0] MSI_REG_ENABLE = 2'd1;
    localparam logic [1:0] MSI_REG_CTRL   = 2'd2;
    localparam logic [1:0] MSI_REG_STATUS = 2'd3;

    // CTRL keeps only vector base [7:0], global enable [8] and tid [31:16]
    localparam logic [31:0] MSI_CTRL_WMASK = 32'hFFFF_01FF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS_ACK = 2'd1,
        ST_MSI     = 2'd2,
        ST_GAP     = 2'd3
    } msi_state_t;

    function automatic logic [255:0] replicate64(input logic [63:0] d);
        return {4{d}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_io_msi_ctrl_if.sv
`default_nettype none
// ============================================================================
// wb_io_msi_ctrl_if
// One bridge channel: master request in, channel response out.
// Revision: 1.0
// ============================================================================
interface wb_io_msi_ctrl_if;
    import wb_io_msi_ctrl_pkg::*;

    wb_cmd_request256_t  req;
    wb_cmd_response256_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface
`default_nettype wire

// File: rtl/wb_msi_prienc.sv
`default_nettype none
// ============================================================================
// wb_msi_prienc
// Lowest-set-bit priority encoder returning index and valid.
// Revision: 1.0
// ============================================================================
module wb_msi_prienc #(
    parameter int N = 8
) (
    input  logic [N-1:0] vec_i,
    output logic [4:0]   idx_o,
    output logic         valid_o
);

    // Scanning downward lets the lowest set bit win the last assignment
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 5'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_io_msi_ctrl.sv
`default_nettype none
// ============================================================================
// wb_io_msi_ctrl
// Interrupt edge latch emitting one-cycle MSI responses, plus PEND/ENABLE/CTRL/STATUS registers.
// Revision: 1.0
// ============================================================================
module wb_io_msi_ctrl
    import wb_io_msi_ctrl_pkg::*;
#(
    parameter int          NIRQ     = 8,
    parameter logic [31:0] BASE_ADR = 32'hFEE2_0000,
    parameter logic [31:0] ADR_MASK = 32'hFFFF_FFE0,
    parameter logic [3:0]  MSI_PRI  = 4'd8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_io_msi_ctrl_if.slave    bus,
    input  logic [NIRQ-1:0]    irq_i
);

    msi_state_t          state_q;
    wb_cmd_response256_t resp_q;
    logic [NIRQ-1:0]     irq_q;
    logic [NIRQ-1:0]     pend_q;
    logic [NIRQ-1:0]     pend_d;
    logic [NIRQ-1:0]     en_q;
    logic [31:0]         ctrl_q;
    logic [5:0]          last_q;

    logic                hit;
    logic [1:0]          lane;
    logic [63:0]         wdat;
    logic                wr_en;
    logic [63:0]         rdata;
    logic [NIRQ-1:0]     active;
    logic [4:0]          pe_idx;
    logic                pe_valid;
    logic                msi_go;
    logic [NIRQ-1:0]     msi_clr;
    logic [NIRQ-1:0]     w1c;
    wb_cmd_response256_t bus_resp;
    wb_cmd_response256_t msi_resp;
    logic                unused_req;

    assign active = pend_q & en_q;

    wb_msi_prienc #(.N(NIRQ)) u_prienc (
        .vec_i   (active),
        .idx_o   (pe_idx),
        .valid_o (pe_valid)
    );

    always_comb begin
        hit   = bus.req.cyc & bus.req.stb &
                ((bus.req.adr & ADR_MASK) == (BASE_ADR & ADR_MASK));
        lane  = bus.req.adr[4:3];
        wdat  = bus.req.dat[{lane, 6'd0} +: 64];
        wr_en = hit & bus.req.we & (|bus.req.sel[{lane, 3'd0} +: 8]) &
                (state_q == ST_IDLE);

        case (lane)
            MSI_REG_PEND:   rdata = 64'(pend_q);
            MSI_REG_ENABLE: rdata = 64'(en_q);
            MSI_REG_CTRL:   rdata = {32'd0, ctrl_q};
            default:        rdata = {55'd0, |active, 2'd0, last_q};
        endcase

        // A bus hit in IDLE always takes precedence over a pending MSI
        msi_go = (state_q == ST_IDLE) & ~hit & ctrl_q[8] & pe_valid;

        msi_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            msi_clr[i] = msi_go && (pe_idx == 5'(i));
        end

        w1c = (wr_en && lane == MSI_REG_PEND) ? wdat[NIRQ-1:0] : '0;

        // New edges are OR-ed in last so a set wins over a same-cycle clear
        pend_d = (pend_q & ~w1c & ~msi_clr) | (irq_i & ~irq_q);

        bus_resp     = '0;
        bus_resp.ack = 1'b1;
        bus_resp.err = WB_ERR_OKAY;
        bus_resp.tid = bus.req.tid;
        bus_resp.dat = replicate64(rdata);

        msi_resp          = '0;
        msi_resp.ack      = 1'b1;
        msi_resp.err      = WB_ERR_IRQ;
        msi_resp.pri      = MSI_PRI;
        msi_resp.tid      = ctrl_q[31:16];
        msi_resp.dat[7:0] = ctrl_q[7:0] + {3'd0, pe_idx};
    end

    assign unused_req = ^bus.req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            resp_q  <= '0;
            irq_q   <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            ctrl_q  <= '0;
            last_q  <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;

            if (wr_en) begin
                case (lane)
                    MSI_REG_ENABLE: en_q   <= wdat[NIRQ-1:0];
                    MSI_REG_CTRL:   ctrl_q <= wdat[31:0] & MSI_CTRL_WMASK;
                    default: ;
                endcase
            end

            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        resp_q  <= bus_resp;
                        state_q <= ST_BUS_ACK;
                    end else if (msi_go) begin
                        resp_q  <= msi_resp;
                        last_q  <= {1'b0, pe_idx};
                        state_q <= ST_MSI;
                    end
                end
                ST_BUS_ACK: begin
                    if (!bus.req.stb) begin
                        resp_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_MSI: begin
                    resp_q  <= '0;
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    resp_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_io_msi_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wb_io_msi_ctrl
// Register table plus directed MSI sequences for wb_io_msi_ctrl.
// Revision: 1.0
// ============================================================================
module tb_wb_io_msi_ctrl;
    import wb_io_msi_ctrl_pkg::*;

    localparam int          NIRQ = 8;
    localparam logic [31:0] BASE = 32'hFEE2_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;

    wb_io_msi_ctrl_if bus();

    wb_io_msi_ctrl #(
        .NIRQ     (NIRQ),
        .BASE_ADR (BASE),
        .ADR_MASK (32'hFFFF_FFE0),
        .MSI_PRI  (4'd8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave),
        .irq_i (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int ack_cnt  = 0;

    typedef struct {
        logic [255:0] dat;
        logic [15:0]  tid;
        logic [3:0]   pri;
        int           cyc;
    } msi_rec_t;
    msi_rec_t msi_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (bus.resp.ack === 1'b1) begin
            ack_cnt++;
            if (bus.resp.err == WB_ERR_IRQ)
                msi_q.push_back('{bus.resp.dat, bus.resp.tid, bus.resp.pri, cyc_cnt});
        end
    end

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [63:0] wdat;
        logic [7:0]  sel;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_access(input logic we, input logic [31:0] adr, input logic [63:0] wdat,
                              input logic [7:0] sel, output logic [63:0] rdat, output int lat);
        logic [1:0]   ln;
        logic [255:0] d;
        logic [31:0]  s;
        logic [15:0]  t;
        ln = adr[4:3];
        d  = {4{~wdat}};
        d[int'(ln)*64 +: 64] = wdat;
        s  = '0;
        s[int'(ln)*8 +: 8] = sel;
        t  = {8'hC3, 3'd0, adr[4:0]};
        bus.req.cyc  = 1'b1;
        bus.req.stb  = 1'b1;
        bus.req.we   = we;
        bus.req.adr  = adr;
        bus.req.dat  = d;
        bus.req.sel  = s;
        bus.req.tid  = t;
        bus.req.cti  = 3'd0;
        bus.req.blen = 8'd0;
        lat  = 0;
        rdat = '0;
        while (lat < 20) begin
            tick();
            lat++;
            if (bus.resp.ack === 1'b1 && bus.resp.err == WB_ERR_OKAY) break;
        end
        if (!(bus.resp.ack === 1'b1 && bus.resp.err == WB_ERR_OKAY)) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout: no ack for adr 0x%0h after %0d cycles, expected ack", adr, lat);
        end else begin
            rdat = bus.resp.dat[63:0];
            for (int k = 1; k < 4; k++)
                check($sformatf("lane%0d_rep", k), bus.resp.dat[k*64 +: 64], rdat);
            check("resp_tid", 64'(bus.resp.tid), 64'(t));
            tick();
            check("hold_ack", 64'(bus.resp.ack), 64'd1);
            check("hold_dat", bus.resp.dat[63:0], rdat);
        end
        bus.req = '0;
        tick();
        check("ack_drop", 64'(bus.resp.ack), 64'd0);
        check("dat_drop", bus.resp.dat[63:0], 64'd0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [63:0] wdat);
        logic [63:0] r;
        int          l;
        bus_access(1'b1, adr, wdat, 8'hFF, r, l);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [63:0] exp);
        logic [63:0] r;
        int          l;
        bus_access(1'b0, adr, 64'd0, 8'hFF, r, l);
        check(name, r, exp);
    endtask

    initial begin
        logic [63:0] r;
        int          l;
        int          t0;
        int          a0;

        tbl[0]  = '{"rd_pend_rst",  1'b0, BASE + 32'h00, 64'd0, 8'hFF, 64'd0};
        tbl[1]  = '{"rd_en_rst",    1'b0, BASE + 32'h08, 64'd0, 8'hFF, 64'd0};
        tbl[2]  = '{"rd_ctrl_rst",  1'b0, BASE + 32'h10, 64'd0, 8'hFF, 64'd0};
        tbl[3]  = '{"rd_stat_rst",  1'b0, BASE + 32'h18, 64'd0, 8'hFF, 64'd0};
        tbl[4]  = '{"wr_en",        1'b1, BASE + 32'h08, 64'hA5, 8'hFF, 64'd0};
        tbl[5]  = '{"rd_en",        1'b0, BASE + 32'h08, 64'd0, 8'hFF, 64'hA5};
        tbl[6]  = '{"wr_en_nosel",  1'b1, BASE + 32'h08, 64'h3C, 8'h00, 64'd0};
        tbl[7]  = '{"rd_en_keep",   1'b0, BASE + 32'h08, 64'd0, 8'hFF, 64'hA5};
        tbl[8]  = '{"wr_en_wide",   1'b1, BASE + 32'h08, 64'hFFFF_FFFF_FFFF_FF5A, 8'h01, 64'd0};
        tbl[9]  = '{"rd_en_wide",   1'b0, BASE + 32'h08, 64'd0, 8'hFF, 64'h5A};
        tbl[10] = '{"wr_ctrl",      1'b1, BASE + 32'h10, 64'h0001_0040, 8'hFF, 64'd0};
        tbl[11] = '{"rd_ctrl",      1'b0, BASE + 32'h10, 64'd0, 8'hFF, 64'h0001_0040};
        tbl[12] = '{"wr_pend_zero", 1'b1, BASE + 32'h00, 64'hFF, 8'hFF, 64'd0};
        tbl[13] = '{"rd_pend",      1'b0, BASE + 32'h00, 64'd0, 8'hFF, 64'd0};
        tbl[14] = '{"wr_stat_ro",   1'b1, BASE + 32'h18, 64'hFFFF, 8'hFF, 64'd0};
        tbl[15] = '{"rd_stat",      1'b0, BASE + 32'h18, 64'd0, 8'hFF, 64'd0};
        tbl[16] = '{"rd_en_byteoff",1'b0, BASE + 32'h0C, 64'd0, 8'hFF, 64'h5A};

        rst     = 1'b1;
        irq     = '0;
        bus.req = '0;
        tick(3);
        check("rst_ack", 64'(bus.resp.ack), 64'd0);
        check("rst_dat", bus.resp.dat[63:0], 64'd0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 17; i++) begin
            bus_access(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].sel, r, l);
            check({tbl[i].name, "_lat"}, 64'(l), 64'd1);
            if (!tbl[i].we) check(tbl[i].name, r, tbl[i].exp);
        end

        // Address just outside the block must be ignored entirely
        a0 = ack_cnt;
        bus.req.cyc = 1'b1;
        bus.req.stb = 1'b1;
        bus.req.we  = 1'b1;
        bus.req.adr = BASE + 32'h28;
        bus.req.sel = '1;
        bus.req.dat = {32{8'h77}};
        tick(5);
        check("nohit_ack", 64'(ack_cnt - a0), 64'd0);
        bus.req = '0;
        tick();
        rd_chk("nohit_en", BASE + 32'h08, 64'h5A);

        // Single MSI from irq 3
        wr(BASE + 32'h08, 64'h08);
        wr(BASE + 32'h10, 64'h0001_0140);
        msi_q.delete();
        a0 = ack_cnt;
        irq[3] = 1'b1;
        t0 = cyc_cnt;
        tick(8);
        check("t1_count", 64'(msi_q.size()), 64'd1);
        check("t1_acks", 64'(ack_cnt - a0), 64'd1);
        if (msi_q.size() >= 1) begin
            check("t1_vec", 64'(msi_q[0].dat[7:0]), 64'h43);
            check("t1_dat_hi", 64'(|msi_q[0].dat[255:8]), 64'd0);
            check("t1_tid", 64'(msi_q[0].tid), 64'h0001);
            check("t1_pri", 64'(msi_q[0].pri), 64'd8);
            check("t1_lat", 64'(msi_q[0].cyc - t0), 64'd2);
        end
        irq[3] = 1'b0;
        rd_chk("t1_pend", BASE + 32'h00, 64'd0);
        rd_chk("t1_stat", BASE + 32'h18, 64'h003);

        // Two simultaneous edges -> two MSIs, lowest first, three cycles apart
        wr(BASE + 32'h08, 64'h21);
        msi_q.delete();
        a0 = ack_cnt;
        irq[0] = 1'b1;
        irq[5] = 1'b1;
        tick(12);
        check("t3_count", 64'(msi_q.size()), 64'd2);
        check("t3_acks", 64'(ack_cnt - a0), 64'd2);
        if (msi_q.size() >= 2) begin
            check("t3_vec0", 64'(msi_q[0].dat[7:0]), 64'h40);
            check("t3_vec1", 64'(msi_q[1].dat[7:0]), 64'h45);
            check("t3_spacing", 64'(msi_q[1].cyc - msi_q[0].cyc), 64'd3);
        end
        irq = '0;
        rd_chk("t3_pend", BASE + 32'h00, 64'd0);
        rd_chk("t3_stat", BASE + 32'h18, 64'h005);

        // Global enable off: pending stays, set beats same-cycle W1C
        wr(BASE + 32'h10, 64'h0001_0040);
        wr(BASE + 32'h08, 64'h04);
        msi_q.delete();
        irq[2] = 1'b1;
        tick(3);
        irq[2] = 1'b0;
        tick(2);
        rd_chk("t4_pend_set", BASE + 32'h00, 64'h4);
        rd_chk("t4_stat", BASE + 32'h18, 64'h105);
        irq[2] = 1'b1;
        bus_access(1'b1, BASE + 32'h00, 64'h4, 8'hFF, r, l);
        irq[2] = 1'b0;
        rd_chk("t4_pend_coinc", BASE + 32'h00, 64'h4);
        tick(2);
        wr(BASE + 32'h00, 64'h4);
        rd_chk("t4_pend_w1c", BASE + 32'h00, 64'h0);
        check("t4_no_msi", 64'(msi_q.size()), 64'd0);

        // Disabled edge stays pending until enabled
        wr(BASE + 32'h08, 64'h00);
        wr(BASE + 32'h10, 64'h0001_0140);
        msi_q.delete();
        irq[1] = 1'b1;
        tick(6);
        check("t6_no_msi", 64'(msi_q.size()), 64'd0);
        rd_chk("t6_stat", BASE + 32'h18, 64'h005);
        rd_chk("t6_pend", BASE + 32'h00, 64'h2);
        irq[1] = 1'b0;
        wr(BASE + 32'h08, 64'h02);
        tick(6);
        check("t6_count", 64'(msi_q.size()), 64'd1);
        if (msi_q.size() >= 1) check("t6_vec", 64'(msi_q[0].dat[7:0]), 64'h41);
        rd_chk("t6_pend_after", BASE + 32'h00, 64'h0);

        // Read issued during the MSI cycle waits for MSI and GAP
        wr(BASE + 32'h08, 64'h80);
        msi_q.delete();
        irq[7] = 1'b1;
        tick(2);
        check("t5_msi_now", 64'({bus.resp.ack, bus.resp.err}), 64'({1'b1, WB_ERR_IRQ}));
        bus_access(1'b0, BASE + 32'h08, 64'd0, 8'hFF, r, l);
        check("t5_rd", r, 64'h80);
        check("t5_lat", 64'(l), 64'd3);
        check("t5_count", 64'(msi_q.size()), 64'd1);
        if (msi_q.size() >= 1) check("t5_vec", 64'(msi_q[0].dat[7:0]), 64'h47);
        irq[7] = 1'b0;
        tick(2);

        // Asynchronous reset while a bus ack is being held
        bus.req.cyc = 1'b1;
        bus.req.stb = 1'b1;
        bus.req.adr = BASE + 32'h10;
        tick();
        check("rst_pre_ack", 64'(bus.resp.ack), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ack", 64'(bus.resp.ack), 64'd0);
        check("rst_async_dat", bus.resp.dat[63:0], 64'd0);
        bus.req = '0;
        tick(2);
        rst = 1'b0;
        tick();
        rd_chk("rst_ctrl", BASE + 32'h10, 64'd0);
        rd_chk("rst_en", BASE + 32'h08, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
